// File: rtl/bus_pkg.sv
// bus_pkg: shared types for masters of the native valid/ready memory bus.
//   bus_req_t   - one registered bus request (valid, wstrb, addr, wdata)
//   WSTRB_RD/WR - strobe encodings; only full-word writes are issued
//   dma_state_t - sequencing states of the DMA initiator
//   word_align  - clears the byte-offset bits of a byte address
package bus_pkg;

   localparam logic [3:0] WSTRB_RD = 4'h0;
   localparam logic [3:0] WSTRB_WR = 4'hF;

   typedef struct packed {
      logic        valid;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_req_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      RGAP = 3'd2,
      WR   = 3'd3,
      WGAP = 3'd4
   } dma_state_t;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// bus_watchdog: flags a bus request that has waited too long for mem_ready.
// Reusable by any master on the native bus.
//   clk, reset  - clock, asynchronous active-high reset
//   mem_valid   - request currently presented by the master
//   mem_ready   - completion from the responder
//   expired     - high in the stall cycle that is the TIMEOUT-th consecutive
//                 cycle of mem_valid=1 with mem_ready=0; the master aborts on it.
//                 TIMEOUT=0 disables the watchdog (expired never rises).
module bus_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic mem_valid,
   input  logic mem_ready,
   output logic expired
);

   // Counter holds stall cycles already elapsed, so it only needs to reach TIMEOUT-1.
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   // Held at zero while mem_valid is low, so every request starts from zero.
   always_comb begin
      cnt_d = cnt_q;
      if (!mem_valid) begin
         cnt_d = '0;
      end else if (!mem_ready && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // A handshake in the same cycle always wins over expiry.
   assign expired = (TIMEOUT != 0) && mem_valid && !mem_ready && (cnt_q == LAST);

endmodule

// File: rtl/bus_dma_initiator.sv
// bus_dma_initiator: bus master that copies cmd_len 32-bit words from cmd_src
// to cmd_dst, one read then one write transaction per word.
//   clk, reset           - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready  - command handshake; cmd_ready is high only in IDLE
//   cmd_src/cmd_dst      - byte addresses, bits[1:0] forced to zero
//   cmd_len              - words to copy (0 = immediate done, no bus traffic)
//   busy                 - high from accept until the done/err pulse
//   done / err           - one-cycle completion / timeout-abort pulses
//   mem_valid/mem_ready  - bus request / completion
//   mem_wstrb            - 4'h0 read, 4'hF write
//   mem_addr/mem_wdata   - word address and write data
//   mem_rdata            - read data, sampled in the mem_ready cycle
//   dbg_state            - current sequencing state
//
// Handshake rules: a transfer on either interface happens in a cycle where
// both valid and ready are high. While mem_valid is high, mem_addr, mem_wstrb
// and mem_wdata do not change; after each bus handshake mem_valid drops for
// exactly one gap cycle, and mem_ready is ignored whenever mem_valid is low.
module bus_dma_initiator
   import bus_pkg::*;
#(
   parameter int LEN_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [31:0]      cmd_src,
   input  logic [31:0]      cmd_dst,
   input  logic [LEN_W-1:0] cmd_len,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             mem_valid,
   input  logic             mem_ready,
   output logic [3:0]       mem_wstrb,
   output logic [31:0]      mem_addr,
   output logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_rdata,
   output dma_state_t       dbg_state
);

   dma_state_t       state_q, state_d;
   bus_req_t         req_q, req_d;
   logic [31:0]      src_q, src_d;
   logic [31:0]      dst_q, dst_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic [31:0]      buf_q, buf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             wd_expired;

   bus_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk       (clk),
      .reset     (reset),
      .mem_valid (req_q.valid),
      .mem_ready (mem_ready),
      .expired   (wd_expired)
   );

   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      src_d   = src_q;
      dst_d   = dst_q;
      rem_d   = rem_q;
      buf_d   = buf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               src_d = word_align(cmd_src);
               dst_d = word_align(cmd_dst);
               rem_d = cmd_len;
               if (cmd_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d     = RD;
                  busy_d      = 1'b1;
                  req_d.valid = 1'b1;
                  req_d.wstrb = WSTRB_RD;
                  req_d.addr  = word_align(cmd_src);
               end
            end
         end
         RD: begin
            if (mem_ready) begin
               buf_d       = mem_rdata;
               req_d.valid = 1'b0;
               state_d     = RGAP;
            end
         end
         RGAP: begin
            state_d     = WR;
            req_d.valid = 1'b1;
            req_d.wstrb = WSTRB_WR;
            req_d.addr  = dst_q;
            req_d.wdata = buf_q;
         end
         WR: begin
            if (mem_ready) begin
               req_d.valid = 1'b0;
               state_d     = WGAP;
               src_d       = src_q + 32'd4;
               dst_d       = dst_q + 32'd4;
               rem_d       = rem_q - LEN_W'(1);
               // Last word: done and busy change with the entry into WGAP,
               // so they are visible during the WGAP cycle itself.
               if (rem_q == LEN_W'(1)) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
               end
            end
         end
         WGAP: begin
            if (rem_q == '0) begin
               state_d = IDLE;
            end else begin
               state_d     = RD;
               req_d.valid = 1'b1;
               req_d.wstrb = WSTRB_RD;
               req_d.addr  = src_q;
            end
         end
         default: begin
            state_d     = IDLE;
            req_d.valid = 1'b0;
            busy_d      = 1'b0;
         end
      endcase

      // Timeout abort overrides the stalled RD/WR; words already written stay.
      if (((state_q == RD) || (state_q == WR)) && wd_expired) begin
         state_d     = IDLE;
         req_d.valid = 1'b0;
         busy_d      = 1'b0;
         err_d       = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         req_q   <= '0;
         src_q   <= '0;
         dst_q   <= '0;
         rem_q   <= '0;
         buf_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         rem_q   <= rem_d;
         buf_q   <= buf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign mem_valid = req_q.valid;
   assign mem_wstrb = req_q.wstrb;
   assign mem_addr  = req_q.addr;
   assign mem_wdata = req_q.wdata;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_bus_dma_initiator.sv
module tb_bus_dma_initiator;
  import bus_pkg::*;

  localparam int LEN_W   = 16;
  localparam int TIMEOUT = 8;
  localparam logic [1:0] EV_RD   = 2'd0;
  localparam logic [1:0] EV_WR   = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;
  localparam logic [1:0] EV_ERR  = 2'd3;
  localparam int NO_END = -1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [31:0]      cmd_src = '0;
  logic [31:0]      cmd_dst = '0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic             busy, done, err;
  logic             mem_valid;
  logic             mem_ready = 1'b0;
  logic [3:0]       mem_wstrb;
  logic [31:0]      mem_addr, mem_wdata, mem_rdata;
  dma_state_t       dbg_state;

  bus_dma_initiator #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // ---------------- responder model ----------------
  // Read contents are a fixed pattern of the word index; copy regions never overlap.
  function automatic logic [31:0] init_val(input logic [9:0] idx);
    return 32'hDEAD_0000 ^ {idx[5:0], 16'h0, idx};
  endfunction

  int resp_delay  = 0;   // extra valid cycles before ready (0 = ready<=valid)
  int hang_at     = -1;  // read handshake number that never gets ready
  int wait_cnt    = 0;
  int rd_hs_total = 0;

  always @(posedge clk) begin
    if (mem_valid && mem_ready && (mem_wstrb == WSTRB_RD)) rd_hs_total <= rd_hs_total + 1;
    wait_cnt  <= mem_valid ? wait_cnt + 1 : 0;
    mem_ready <= mem_valid && (wait_cnt >= resp_delay) &&
                 !((mem_wstrb == WSTRB_RD) && (rd_hs_total == hang_at));
  end

  assign mem_rdata = mem_ready ? init_val(mem_addr[11:2]) : 32'hBAD0_BAD0;

  // ---------------- scoreboard ----------------
  logic [65:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic compare_ev(input string name, input logic [65:0] act);
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL %s: got unexpected event %h expected none (cycle %0d)", name, act, cyc);
    end else begin
      check(name, act, exp_q.pop_front());
    end
  endtask

  // ---------------- monitor ----------------
  logic        prev_valid = 1'b0;
  logic        prev_hs    = 1'b0;
  logic [31:0] prev_addr  = '0;
  logic [31:0] prev_wdata = '0;
  logic [3:0]  prev_wstrb = '0;
  int          vld_rises  = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_valid && prev_valid && !prev_hs) begin
        check("hold_addr",  66'(mem_addr),  66'(prev_addr));
        check("hold_wstrb", 66'(mem_wstrb), 66'(prev_wstrb));
        check("hold_wdata", 66'(mem_wdata), 66'(prev_wdata));
      end
      if (prev_hs) check("gap_after_hs", 66'(mem_valid), 66'd0);
      if (mem_valid && !prev_valid) vld_rises <= vld_rises + 1;
      if (mem_valid && mem_ready) begin
        if (mem_wstrb == WSTRB_WR) compare_ev("wr_xfer", {EV_WR, mem_addr, mem_wdata});
        else compare_ev("rd_xfer", {EV_RD, mem_addr, 32'h0});
      end
      if (done) compare_ev("done_pulse", {EV_DONE, 32'h0, 32'(cyc)});
      if (err) begin
        compare_ev("err_pulse", {EV_ERR, 32'h0, 32'(cyc)});
        check("err_valid_low", 66'(mem_valid), 66'd0);
      end
      if (done || err) begin
        check("done_err_excl", 66'(done && err), 66'd0);
        check("busy_at_end",   66'(busy), 66'd0);
      end
    end
    prev_valid <= mem_valid;
    prev_hs    <= mem_valid && mem_ready;
    prev_addr  <= mem_addr;
    prev_wdata <= mem_wdata;
    prev_wstrb <= mem_wstrb;
  end

  // ---------------- driver tasks ----------------
  // Expected bus events in order: rd0, wr0, rd1, wr1, ...
  task automatic push_copy(input logic [31:0] src, input logic [31:0] dst,
                           input int n_rd, input int n_wr);
    logic [31:0] sa, da;
    for (int k = 0; k < ((n_rd > n_wr) ? n_rd : n_wr); k++) begin
      sa = src + 32'(4 * k);
      da = dst + 32'(4 * k);
      if (k < n_rd) exp_q.push_back({EV_RD, sa, 32'h0});
      if (k < n_wr) exp_q.push_back({EV_WR, da, init_val(sa[11:2])});
    end
  endtask

  // end_lat: cycles from the accept cycle to the done/err pulse (NO_END = none).
  task automatic issue(input logic [31:0] src, input logic [31:0] dst,
                       input logic [LEN_W-1:0] len, input logic [1:0] end_kind,
                       input int end_lat);
    int acc;
    @(negedge clk);
    check("cmd_ready_idle", 66'(cmd_ready), 66'd1);
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    cmd_valid = 1'b1;
    acc = cyc;
    if (end_lat != NO_END) exp_q.push_back({end_kind, 32'h0, 32'(acc + end_lat)});
    @(negedge clk);
    cmd_valid = 1'b0;
    if (len != '0) begin
      check("busy_after_accept", 66'(busy), 66'd1);
      check("cmd_ready_busy",    66'(cmd_ready), 66'd0);
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    check("drain_queue", 66'(exp_q.size()), 66'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  r;
    logic hit;

    @(negedge clk);
    check("rst_mem_valid", 66'(mem_valid), 66'd0);
    check("rst_mem_wstrb", 66'(mem_wstrb), 66'd0);
    check("rst_mem_addr",  66'(mem_addr),  66'd0);
    check("rst_mem_wdata", 66'(mem_wdata), 66'd0);
    check("rst_busy",      66'(busy),      66'd0);
    check("rst_done",      66'(done),      66'd0);
    check("rst_err",       66'(err),       66'd0);
    check("rst_cmd_ready", 66'(cmd_ready), 66'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 1: three words, 1-cycle responder, 6 cycles per word -> done at accept+18
    push_copy(32'h100, 32'h200, 3, 3);
    issue(32'h100, 32'h200, 16'd3, EV_DONE, 18);
    wait_drain(100);

    // 2: zero length -> done next cycle, no bus request
    r = vld_rises;
    issue(32'h40, 32'h80, 16'd0, EV_DONE, 1);
    wait_drain(20);
    check("len0_no_bus", 66'(vld_rises), 66'(r));

    // 3: slow responder (6 stall cycles, below TIMEOUT) -> 16 cycles per word;
    //    a command offered while busy must be ignored.
    resp_delay = 5;
    push_copy(32'h400, 32'h500, 2, 2);
    issue(32'h400, 32'h500, 16'd2, EV_DONE, 32);
    repeat (3) @(negedge clk);
    cmd_src   = 32'h40;
    cmd_dst   = 32'h80;
    cmd_len   = 16'd5;
    cmd_valid = 1'b1;
    repeat (4) @(negedge clk);
    cmd_valid = 1'b0;
    wait_drain(200);
    resp_delay = 0;

    // 4: second read never answered -> err after 8 stall cycles, only word 0 written
    hang_at = rd_hs_total + 1;
    push_copy(32'h600, 32'h700, 1, 1);
    issue(32'h600, 32'h700, 16'd3, EV_ERR, 15);
    wait_drain(100);
    hang_at = -1;
    check("idle_after_err", 66'(cmd_ready), 66'd1);

    // 5: source address wraps past 0xFFFF_FFFC to 0x0
    push_copy(32'hFFFF_FFFC, 32'h300, 2, 2);
    issue(32'hFFFF_FFFC, 32'h300, 16'd2, EV_DONE, 12);
    wait_drain(100);

    // 6: reset during the write of word 1 of 4
    push_copy(32'h800, 32'h900, 2, 1);
    issue(32'h800, 32'h900, 16'd4, EV_DONE, NO_END);
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((exp_q.size() == 0) && (dbg_state == WR)) begin
        hit = 1'b1;
        break;
      end
    end
    check("reached_wr_word1", 66'(hit), 66'd1);
    reset = 1'b1;
    #1;
    check("rst_mid_valid", 66'(mem_valid), 66'd0);
    check("rst_mid_busy",  66'(busy),      66'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", 66'(cmd_ready), 66'd1);
    check("post_rst_busy",      66'(busy),      66'd0);
    check("post_rst_done",      66'(done),      66'd0);
    exp_q.delete();
    push_copy(32'hA00, 32'hB00, 1, 1);
    issue(32'hA00, 32'hB00, 16'd1, EV_DONE, 6);
    wait_drain(50);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1, "simulation time limit");
  end

endmodule
